// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU; result on a {hi,lo} pair.
// Latency: multiply MUL_LAT+1 cycles after accept, divide WIDTH+1, divide-by-zero 1 (valid in DONE).
// Backpressure: stall freezes IF..EX from accept through the last busy cycle; flush aborts at once.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             sign,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int NMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sign_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic             start_any;
  logic             accept;
  logic             div_by_zero;
  logic             mul_last;
  logic             div_last;

  // Multiply datapath: full-width product of the latched operands.
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  // Divide datapath: one restoring step per DIV cycle on magnitudes.
  logic [WIDTH-1:0] div_b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  assign start_any   = start_mul | start_div;
  assign accept      = (state == S_IDLE) & start_any & ~flush;
  // Mul wins when both starts are high, so only a pure divide can short-circuit on zero.
  assign div_by_zero = ~start_mul & (op_b == '0);
  assign mul_last    = (state == S_MUL) & (cnt == MUL_LAST);
  assign div_last    = (state == S_DIV) & (cnt == DIV_LAST);

  assign ext_a   = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b   = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = ext_a * ext_b;

  assign div_b_mag = (sign_q & b_q[WIDTH-1]) ? -b_q : b_q;
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign ge        = shifted >= {1'b0, div_b_mag};
  // Partial remainder is always below the divisor, so the W-bit difference is exact.
  assign rem_nxt   = ge ? (shifted[WIDTH-1:0] - div_b_mag) : shifted[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], ge};
  assign neg_quo   = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_rem   = sign_q & a_q[WIDTH-1];
  assign quo_fin   = neg_quo ? -quo_nxt : quo_nxt;
  assign rem_fin   = neg_rem ? -rem_nxt : rem_nxt;

  // Pipeline-facing status; stall is forced low in reset so a held start cannot freeze the core.
  assign busy  = (state == S_MUL) | (state == S_DIV);
  assign valid = (state == S_DONE) & ~flush;
  assign stall = rst_n & ~flush & (((state == S_IDLE) & start_any) | busy);

  // Next-state selection; flush overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (start_mul)        state_nxt = S_MUL;
          else if (div_by_zero) state_nxt = S_DONE;
          else                  state_nxt = S_DIV;
        end
      end
      S_MUL:   if (cnt == MUL_LAST) state_nxt = S_DONE;
      S_DIV:   if (cnt == DIV_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter: cleared on accept and on any state change, advanced while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (accept || (state_nxt != state)) cnt <= '0;
    else if (busy)                           cnt <= cnt + CW'(1);
  end

  // Operand capture at accept; the forwarded inputs may change freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
    end else if (accept) begin
      a_q    <= op_a;
      b_q    <= op_b;
      sign_q <= sign;
    end
  end

  // Divider working registers: quotient shifts in from the dividend magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      quo_q <= (sign & op_a[WIDTH-1]) ? -op_a : op_a;
      rem_q <= '0;
    end else if ((state == S_DIV) && !flush) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

  // Result registers load on DONE entry only, so they hold across flushes and idle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && !start_mul && div_by_zero) begin
      hi <= op_a;
      lo <= '1;
    end else if (mul_last && !flush) begin
      hi <= product[2*WIDTH-1:WIDTH];
      lo <= product[WIDTH-1:0];
    end else if (div_last && !flush) begin
      hi <= rem_fin;
      lo <= quo_fin;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner cases plus random ops against an arithmetic reference.
// Latency: each op is followed to its valid pulse, bounded by a cycle budget.
// Backpressure: start is held while stall is high, as the EX stage would.
module tb_muldiv_ctrl;

  localparam int W  = 32;
  localparam int ML = 2;

  logic         clk;
  logic         rst_n;
  logic         start_mul;
  logic         start_div;
  logic         sign;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         stall;
  logic         busy;
  logic         valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks;
  int n_pass;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  muldiv_ctrl #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_mul (start_mul),
    .start_div (start_div),
    .sign      (sign),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .stall     (stall),
    .busy      (busy),
    .valid     (valid),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result and timing from plain arithmetic.
  task automatic model(input bit m, input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int n, output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb, p;
    if (m) begin
      sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
      n  = ML;
    end else if (b == '0) begin
      eh = a;
      el = '1;
      n  = 0;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa / sb;
      el = p[31:0];
      p  = sa % sb;
      eh = p[31:0];
      n  = W;
    end else begin
      el = a / b;
      eh = a % b;
      n  = W;
    end
  endtask

  // Issue one op, hold start while stalled, scramble operands after accept, check timing and result.
  task automatic run_op(input string tag, input bit m, input bit d, input bit sg,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int n, vat, nst;
    logic [W-1:0] eh, el;
    model(m, sg, a, b, n, eh, el);
    @(negedge clk);
    start_mul = m; start_div = d; sign = sg; op_a = a; op_b = b;
    #1;
    vat = -1; nst = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(negedge clk);
        op_a = $urandom; op_b = $urandom; sign = 1'($urandom);
        #1;
      end
      if (stall) nst++;
      if (valid) begin
        vat = k;
        break;
      end
    end
    start_mul = 1'b0; start_div = 1'b0;
    check_eq({tag, ".valid_cycle"}, 64'(vat), 64'(n + 1));
    check_eq({tag, ".stall_cycles"}, 64'(nst), 64'(n + 1));
    check_eq({tag, ".hi"}, 64'(hi), 64'(eh));
    check_eq({tag, ".lo"}, 64'(lo), 64'(el));
    last_hi = eh; last_lo = el;
    @(negedge clk);
    #1;
    check_eq({tag, ".valid_pulse"}, 64'(valid), 64'd0);
    check_eq({tag, ".hold_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; start_mul = 1'b0; start_div = 1'b0; sign = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0;
    last_hi = '0; last_lo = '0;
    #12;
    check_eq("rst.stall", 64'(stall), 64'd0);
    check_eq("rst.busy",  64'(busy),  64'd0);
    check_eq("rst.valid", 64'(valid), 64'd0);
    check_eq("rst.hilo",  {32'(hi), 32'(lo)}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7",   1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    run_op("div_m7_2",     1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf",      1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_m1_2",    1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    run_op("multu_m1_2",   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    run_op("divu_5_0",     1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    run_op("both_starts",  1'b1, 1'b1, 1'b0, 32'd12345, 32'd678);
    run_op("div_m9_m4",    1'b0, 1'b1, 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC);

    // Flush ten cycles into a divide: stall drops at once, no result, hi/lo kept.
    begin
      int seen;
      @(negedge clk);
      start_div = 1'b1; sign = 1'b0; op_a = 32'd1000; op_b = 32'd3;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      flush = 1'b1;
      #1;
      check_eq("flush.stall", 64'(stall), 64'd0);
      @(negedge clk);
      flush = 1'b0; start_div = 1'b0;
      #1;
      check_eq("flush.idle", 64'(busy), 64'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk); #1;
        if (valid) seen++;
      end
      check_eq("flush.no_valid", 64'(seen), 64'd0);
      check_eq("flush.hi", 64'(hi), 64'(last_hi));
      check_eq("flush.lo", 64'(lo), 64'(last_lo));
    end

    // Reset in the middle of a divide with the start still held.
    begin
      @(negedge clk);
      start_div = 1'b1; sign = 1'b1; op_a = 32'd77; op_b = 32'd5;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst.stall", 64'(stall), 64'd0);
      check_eq("midrst.busy",  64'(busy),  64'd0);
      check_eq("midrst.valid", 64'(valid), 64'd0);
      check_eq("midrst.hilo",  {32'(hi), 32'(lo)}, 64'd0);
      @(negedge clk);
      start_div = 1'b0; rst_n = 1'b1;
      @(negedge clk); #1;
      check_eq("midrst.idle_busy",  64'(busy),  64'd0);
      check_eq("midrst.idle_stall", 64'(stall), 64'd0);
    end

    // Random mix of multiplies, divides (including zero divisors) and double starts.
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [W-1:0] a, b;
      kind = $urandom_range(0, 2);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = b & 32'h0000_00FF;
        2: a = a & 32'h0000_FFFF;
        default: ;
      endcase
      run_op("rand", (kind != 1), (kind != 0), 1'($urandom), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
